// File: rtl/clk_div_multi.sv
// clk_div_multi: CH independent, runtime-programmable ~50% duty clock dividers with a one-cycle tick per divided rising edge.
// Optional macro CLK_DIV_MULTI_PHASE_SYNC_EN adds a 'sync' input that phase-aligns every enabled channel.
module clk_div_multi #(
  parameter int CLK_FREQ     = 65_000_000,
  parameter int DEFAULT_FREQ = 100,
  parameter int CH           = 4,
  parameter int CNT_W        = 26,
  parameter int CH_W         = 4
) (
  input  logic             clk65MHz,
  input  logic             rst,
  input  logic [CH-1:0]    en,
`ifdef CLK_DIV_MULTI_PHASE_SYNC_EN
  input  logic             sync,
`endif
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  output logic [CH-1:0]    clk_div,
  output logic [CH-1:0]    tick
);

  localparam logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(CLK_FREQ / DEFAULT_FREQ / 2);

  logic [CH-1:0] pending;
  logic [CH-1:0] wr_hit;
  logic          sync_req;

`ifdef CLK_DIV_MULTI_PHASE_SYNC_EN
  assign sync_req = sync;
`else
  assign sync_req = 1'b0;
`endif

  // Config handshake: a transfer happens on a rising edge with cfg_valid & cfg_ready.
  // A channel refuses new config while it still holds an unapplied update; out-of-range
  // channel numbers are always accepted and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pending[i];
    end
  end

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CH; i++) begin
      wr_hit[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] shadow;
    logic             div_q;
    logic             tick_q;
    logic             pend_q;
    logic             active;
    logic             wrap;

    assign active = en[g] && (half != '0);
    assign wrap   = (count == half - CNT_W'(1));

    always_ff @(posedge clk65MHz or posedge rst) begin
      if (rst) begin
        count  <= '0;
        half   <= DEFAULT_HALF;
        shadow <= '0;
        div_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (!active) begin
          // Idle: hold phase 0 and take any pending update immediately.
          count <= '0;
          div_q <= 1'b0;
          if (pend_q) begin
            half   <= shadow;
            pend_q <= 1'b0;
          end
        end else if (sync_req) begin
          count <= '0;
          div_q <= 1'b0;
          if (pend_q) begin
            half   <= shadow;
            pend_q <= 1'b0;
          end
        end else if (wrap) begin
          // Half-period boundary: the only safe point to swap in a new period.
          count  <= '0;
          div_q  <= ~div_q;
          tick_q <= ~div_q;
          if (pend_q) begin
            half   <= shadow;
            pend_q <= 1'b0;
          end
        end else begin
          count <= count + CNT_W'(1);
        end
        if (wr_hit[g]) begin
          shadow <= cfg_half;
          pend_q <= 1'b1;
        end
      end
    end

    assign clk_div[g] = div_q;
    assign tick[g]    = tick_q;
    assign pending[g] = pend_q;
  end

endmodule
